// File: rtl/scc_pkg.sv
// -----------------------------------------------------------------------------
// scc_pkg
// Shared types and constants for the memory/write-back stage.
//   mwb_state_t : stage FSM states (IDLE, MEM, WB)
//   FLAG_*      : bit positions of N, C, Z, V inside the 4-bit CPSR vector
// -----------------------------------------------------------------------------
package scc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      WB   = 2'd2
   } mwb_state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/mem_wb_stage_cpsr_reg.sv
// -----------------------------------------------------------------------------
// cpsr_reg
// 4-bit condition-flag register {N,C,Z,V} with write enable.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset (clears flags)
//   we   in   load d on the next rising edge
//   d    in   new flags
//   q    out  current flags
// -----------------------------------------------------------------------------
module cpsr_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [3:0] d,
   output logic [3:0] q
);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (we) q <= d;
   end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Stage after execute: accepts one EX result per handshake, performs the
// optional data-memory load/store, drives the register-file write port and
// holds the CPSR flags. EX is stalled (in_ready low) while an access is
// outstanding; a timeout counter bounds the wait on mem_ready.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid / in_ready           EX handshake (ready only in IDLE)
//   in_result, in_flags(_we)      ALU result (+carry bit, unused) and flags
//   in_dest_reg, in_w_enable,
//   in_w_select, in_imm_value     register write control / immediate source
//   in_is_load, in_is_store,
//   in_addr, in_store_data        memory operation
//   mem_req/we/addr/wdata         memory request, held until mem_ready
//   mem_ready, mem_rdata          memory completion and read data
//   rf_we/waddr/wdata             register-file write port (one-cycle strobe)
//   cpsr_flags                    {N,C,Z,V}
//   bus_err                       sticky: an access timed out
//   retire                        one-cycle pulse per completed instruction
// -----------------------------------------------------------------------------
module mem_wb_stage
   import scc_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 3,
   parameter int MEM_ADDR_W  = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W:0]       in_result,
   input  logic [3:0]            in_flags,
   input  logic                  in_flags_we,
   input  logic [REG_ADDR_W-1:0] in_dest_reg,
   input  logic                  in_w_enable,
   input  logic                  in_w_select,
   input  logic [DATA_W-1:0]     in_imm_value,
   input  logic                  in_is_load,
   input  logic                  in_is_store,
   input  logic [DATA_W-1:0]     in_addr,
   input  logic [DATA_W-1:0]     in_store_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ready,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic [3:0]            cpsr_flags,
   output logic                  bus_err,
   output logic                  retire
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   mwb_state_t            state, state_nxt;
   logic [CNT_W-1:0]      wait_cnt;
   logic                  lat_load;
   logic                  lat_wen;
   logic [REG_ADDR_W-1:0] lat_dest;
   logic                  accept;
   logic                  is_mem;
   logic                  unused_bits;

   // Carry-out and the pointer bits above the memory window are not used here.
   assign unused_bits = ^{in_result[DATA_W], in_addr[DATA_W-1:MEM_ADDR_W]};

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;
   assign is_mem   = in_is_load | in_is_store;
   // Decoded from state so an asynchronous reset drops the request at once.
   assign mem_req  = (state == MEM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept && is_mem) state_nxt = MEM;
         // mem_ready is tested before the timeout so it wins on the last cycle.
         MEM:  if (mem_ready)              state_nxt = lat_load ? WB : IDLE;
               else if (wait_cnt == CNT_LAST) state_nxt = IDLE;
         WB:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         bus_err   <= 1'b0;
         retire    <= 1'b0;
         wait_cnt  <= '0;
         lat_load  <= 1'b0;
         lat_wen   <= 1'b0;
         lat_dest  <= '0;
      end else begin
         rf_we  <= 1'b0;
         retire <= 1'b0;

         if (accept) begin
            if (is_mem) begin
               // Load takes priority when both load and store are flagged.
               mem_we    <= ~in_is_load;
               mem_addr  <= in_addr[MEM_ADDR_W-1:0];
               mem_wdata <= in_store_data;
               lat_load  <= in_is_load;
               lat_wen   <= in_w_enable;
               lat_dest  <= in_dest_reg;
               wait_cnt  <= '0;
            end else begin
               rf_we    <= in_w_enable;
               rf_waddr <= in_dest_reg;
               rf_wdata <= in_w_select ? in_imm_value : in_result[DATA_W-1:0];
               retire   <= 1'b1;
            end
         end

         if (state == MEM) begin
            if (mem_ready) begin
               // Load: write-back strobe and retire land in the WB cycle.
               // Store: retire lands in the IDLE cycle that follows.
               retire <= 1'b1;
               if (lat_load) begin
                  rf_we    <= lat_wen;
                  rf_waddr <= lat_dest;
                  rf_wdata <= mem_rdata;
               end
            end else if (wait_cnt == CNT_LAST) begin
               bus_err <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
      end
   end

   cpsr_reg u_cpsr (
      .clk (clk),
      .rst (rst),
      .we  (accept & in_flags_we & ~is_mem),
      .d   (in_flags),
      .q   (cpsr_flags)
   );

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed bench for mem_wb_stage (MEM_TIMEOUT = 4). Expected register-file
// writes are queued when an instruction is driven and compared by a monitor
// whenever the stage retires.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

   localparam int DW = 32;
   localparam int RW = 3;
   localparam int AW = 16;

   typedef struct {
      logic          rf_we;
      logic [RW-1:0] waddr;
      logic [DW-1:0] wdata;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW:0]   in_result;
   logic [3:0]    in_flags;
   logic          in_flags_we;
   logic [RW-1:0] in_dest_reg;
   logic          in_w_enable;
   logic          in_w_select;
   logic [DW-1:0] in_imm_value;
   logic          in_is_load;
   logic          in_is_store;
   logic [DW-1:0] in_addr;
   logic [DW-1:0] in_store_data;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic          rf_we;
   logic [RW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [3:0]    cpsr_flags;
   logic          bus_err;
   logic          retire;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_wb_stage #(
      .DATA_W(DW), .REG_ADDR_W(RW), .MEM_ADDR_W(AW), .MEM_TIMEOUT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_flags(in_flags), .in_flags_we(in_flags_we),
      .in_dest_reg(in_dest_reg), .in_w_enable(in_w_enable),
      .in_w_select(in_w_select), .in_imm_value(in_imm_value),
      .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_addr(in_addr), .in_store_data(in_store_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .cpsr_flags(cpsr_flags), .bus_err(bus_err), .retire(retire)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; in_result = '0; in_flags = '0; in_flags_we = 0;
      in_dest_reg = '0; in_w_enable = 0; in_w_select = 0; in_imm_value = '0;
      in_is_load = 0; in_is_store = 0; in_addr = '0; in_store_data = '0;
   endtask

   task automatic set_alu(input logic [RW-1:0] rd, input logic sel,
                          input logic [DW-1:0] val, input logic fwe,
                          input logic [3:0] fl);
      clear_inputs();
      in_valid = 1; in_dest_reg = rd; in_w_enable = 1; in_w_select = sel;
      if (sel) in_imm_value = val;
      else     in_result = {1'b1, val};    // carry bit must be ignored
      in_flags_we = fwe; in_flags = fl;
      sb.push_back('{1'b1, rd, val});
   endtask

   task automatic set_mem(input logic ld, input logic [RW-1:0] rd,
                          input logic [DW-1:0] addr, input logic [DW-1:0] wd);
      clear_inputs();
      in_valid = 1; in_is_load = ld; in_is_store = ~ld; in_dest_reg = rd;
      in_w_enable = 1; in_addr = addr; in_store_data = wd;
      in_flags_we = 1; in_flags = 4'b1111;  // memory ops must leave CPSR alone
   endtask

   // Scoreboard monitor: every retire pops one expected write-back.
   always @(negedge clk) begin
      if (!rst) begin
         if (retire) begin
            if (sb.size() == 0) begin
               check("retire_unexpected", 32'(retire), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rf_we", 32'(rf_we), 32'(e.rf_we));
               if (e.rf_we) begin
                  check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                  check("rf_wdata", rf_wdata, e.wdata);
               end
            end
         end else if (rf_we) begin
            check("rf_we_without_retire", 32'(rf_we), 32'd0);
         end
      end
   end

   initial begin
      int low;
      clear_inputs();
      mem_ready = 0; mem_rdata = '0;
      rst = 1;
      repeat (2) tick();

      // Reset state
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_outputs", {mem_req, mem_we, rf_we, retire, bus_err, cpsr_flags},
            32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      @(negedge clk) rst = 0;
      tick();

      // Single ALU op: r3 <= 5, flags 0010
      set_alu(3'd3, 1'b0, 32'h5, 1'b1, 4'b0010);
      tick();
      clear_inputs();
      check("alu_rf_we", 32'(rf_we), 32'd1);
      check("alu_cpsr", 32'(cpsr_flags), 32'b0010);
      check("alu_retire", 32'(retire), 32'd1);
      tick();

      // Back-to-back: immediate to r1, then ALU 7 to r2
      check("b2b_ready0", 32'(in_ready), 32'd1);
      set_alu(3'd1, 1'b1, 32'hFFFF_FFF0, 1'b0, 4'b0000);
      tick();
      check("b2b_ready1", 32'(in_ready), 32'd1);
      set_alu(3'd2, 1'b0, 32'h7, 1'b0, 4'b0000);
      tick();
      clear_inputs();
      check("b2b_ready2", 32'(in_ready), 32'd1);
      check("b2b_cpsr_kept", 32'(cpsr_flags), 32'b0010);
      tick();

      // Stray mem_ready in IDLE must be ignored
      mem_ready = 1; mem_rdata = 32'h1111_1111;
      tick();
      mem_ready = 0;
      check("stray_ready_no_retire", 32'(retire), 32'd0);

      // Load r4 from 0x40; ready on the 4th MEM cycle (last counted cycle)
      set_mem(1'b1, 3'd4, 32'h0000_0040, 32'h0);
      sb.push_back('{1'b1, 3'd4, 32'hDEAD_BEEF});
      tick();
      clear_inputs();
      check("ld_req", 32'(mem_req), 32'd1);
      check("ld_we", 32'(mem_we), 32'd0);
      check("ld_addr", 32'(mem_addr), 32'h40);
      low = 0;
      for (int i = 0; i < 6; i++) begin
         if (!in_ready) low++;
         if (i == 3) begin mem_ready = 1; mem_rdata = 32'hDEAD_BEEF; end
         else begin mem_ready = 0; mem_rdata = '0; end
         if (i == 4) check("ld_wb_rf_we", 32'(rf_we), 32'd1);
         tick();
      end
      mem_ready = 0;
      check("ld_ready_low_cycles", 32'(low), 32'd5);
      check("ld_cpsr_kept", 32'(cpsr_flags), 32'b0010);
      check("ld_no_bus_err", 32'(bus_err), 32'd0);

      // Store 0x1234 to 0x10
      set_mem(1'b0, 3'd6, 32'h0000_0010, 32'h0000_1234);
      sb.push_back('{1'b0, 3'd0, 32'h0});
      tick();
      clear_inputs();
      for (int i = 0; i < 2; i++) begin
         check("st_req", 32'(mem_req), 32'd1);
         check("st_we", 32'(mem_we), 32'd1);
         check("st_addr", 32'(mem_addr), 32'h0010);
         check("st_wdata", mem_wdata, 32'h1234);
         tick();
      end
      mem_ready = 1;
      tick();
      mem_ready = 0;
      check("st_done_idle", 32'(in_ready), 32'd1);
      check("st_retire", 32'(retire), 32'd1);
      tick();
      check("st_retire_once", 32'(retire), 32'd0);

      // Timeout: load with no mem_ready
      set_mem(1'b1, 3'd5, 32'h0000_0080, 32'h0);
      tick();
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         check("to_req_held", 32'(mem_req), 32'd1);
         tick();
      end
      check("to_req_last", 32'(mem_req), 32'd1);
      check("to_no_err_yet", 32'(bus_err), 32'd0);
      tick();
      check("to_idle", 32'(in_ready), 32'd1);
      check("to_bus_err", 32'(bus_err), 32'd1);
      check("to_no_rf_we", 32'(rf_we), 32'd0);
      check("to_no_retire", 32'(retire), 32'd0);

      // Next ALU op proceeds normally; bus_err stays set
      set_alu(3'd6, 1'b0, 32'h55, 1'b1, 4'b1001);
      tick();
      clear_inputs();
      check("post_to_retire", 32'(retire), 32'd1);
      check("post_to_cpsr", 32'(cpsr_flags), 32'b1001);
      check("bus_err_sticky", 32'(bus_err), 32'd1);
      tick();

      // Reset in the second MEM cycle of a load
      set_mem(1'b1, 3'd7, 32'h0000_0020, 32'h0);
      tick();
      clear_inputs();
      tick();
      check("rm_req_before", 32'(mem_req), 32'd1);
      #2 rst = 1;
      #1;
      check("rm_req_async", 32'(mem_req), 32'd0);
      check("rm_outputs", {mem_we, rf_we, retire, bus_err, cpsr_flags}, 32'd0);
      check("rm_mem_addr", 32'(mem_addr), 32'd0);
      @(negedge clk) rst = 0;
      tick();
      check("rm_ready_after", 32'(in_ready), 32'd1);
      check("rm_req_after", 32'(mem_req), 32'd0);
      repeat (2) tick();
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      n_errors++;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
